// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch redirect controller: target-source encoding and FSM states.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_ALU  = 2'b01,
    BR_MEM  = 2'b10
  } lc3b_br_src;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FLUSH,
    RD_REDIRECT
  } lc3b_redir_state;

  localparam logic [15:0] PC_STEP = 16'h0002;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Resolve inputs from MEM/WB plus flush/redirect handshake toward fetch.
interface branch_redirect_ctrl_if;
  logic        resolve_valid;
  logic [1:0]  br_ctrl;
  logic [15:0] aluout;
  logic [15:0] mem_data;
  logic [15:0] predict_addr;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        redirect_ready;
  logic        stall_resolve;

  modport slave (
    input  resolve_valid, br_ctrl, aluout, mem_data, predict_addr, redirect_ready,
    output flush, redirect_valid, redirect_pc, stall_resolve
  );

  modport master (
    output resolve_valid, br_ctrl, aluout, mem_data, predict_addr, redirect_ready,
    input  flush, redirect_valid, redirect_pc, stall_resolve
  );
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         inc,
  input  logic         clk,
  input  logic         reset_n,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  count <= '0;
    else if (inc && count != '1)   count <= count + W'(1);
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Pipeline recovery sequencer: detects mispredicted control flow at MEM/WB, squashes
// younger stages, hands fetch the corrected PC, and tracks branch statistics.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  branch_redirect_ctrl_if.slave bus,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispredict_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  lc3b_redir_state   state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              acc, acc_nxt;
  logic [15:0]       pc_q, pc_nxt;

  logic        is_br, mismatch, rv, hs;
  logic        br_inc, mp_inc, flush_c, stall_c;
  logic [15:0] target;

  // br_ctrl=11 falls out as "not a branch" because only ALU/MEM codes match.
  assign is_br    = bus.resolve_valid & (bus.br_ctrl == BR_ALU || bus.br_ctrl == BR_MEM);
  assign target   = ((bus.br_ctrl == BR_ALU) ? bus.aluout : bus.mem_data) + PC_STEP;
  assign mismatch = is_br & (target != bus.predict_addr);

  assign rv = (state != RD_IDLE) & ~acc;
  assign hs = rv & bus.redirect_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RD_IDLE;
      fcnt  <= '0;
      acc   <= 1'b0;
      pc_q  <= 16'h0000;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      acc   <= acc_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    acc_nxt   = acc;
    pc_nxt    = pc_q;
    flush_c   = 1'b0;
    stall_c   = 1'b0;
    br_inc    = 1'b0;
    mp_inc    = 1'b0;
    case (state)
      RD_IDLE: begin
        br_inc = is_br;
        if (mismatch) begin
          mp_inc    = 1'b1;
          pc_nxt    = target;
          fcnt_nxt  = FCNT_INIT;
          acc_nxt   = 1'b0;
          state_nxt = RD_FLUSH;
        end
      end
      RD_FLUSH: begin
        flush_c = 1'b1;
        stall_c = 1'b1;
        if (hs) acc_nxt = 1'b1;
        // Redirect may already have been taken during the flush window; skip REDIRECT then.
        if (fcnt == '0) state_nxt = (acc | hs) ? RD_IDLE : RD_REDIRECT;
        else            fcnt_nxt  = fcnt - FCNT_W'(1);
      end
      RD_REDIRECT: begin
        stall_c = 1'b1;
        if (hs) state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign bus.flush          = flush_c;
  assign bus.stall_resolve  = stall_c;
  assign bus.redirect_valid = rv;
  assign bus.redirect_pc    = pc_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .inc(br_inc), .clk(clk), .reset_n(reset_n), .count(branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .inc(mp_inc), .clk(clk), .reset_n(reset_n), .count(mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: one 16-bit-counter instance and one 4-bit one.
module tb_branch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl_if a ();
  branch_redirect_ctrl_if b ();

  logic [15:0] a_br, a_mp;
  logic [3:0]  b_br, b_mp;

  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(rst_n), .bus(a.slave),
    .branch_cnt(a_br), .mispredict_cnt(a_mp)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_b (
    .clk(clk), .reset_n(rst_n), .bus(b.slave),
    .branch_cnt(b_br), .mispredict_cnt(b_mp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic fl, input logic rv, input logic st,
                       input logic [15:0] br, input logic [15:0] mp);
    chk({tag, ".flush"}, 32'(a.flush), 32'(fl));
    chk({tag, ".rv"},    32'(a.redirect_valid), 32'(rv));
    chk({tag, ".stall"}, 32'(a.stall_resolve), 32'(st));
    chk({tag, ".brcnt"}, 32'(a_br), 32'(br));
    chk({tag, ".mpcnt"}, 32'(a_mp), 32'(mp));
  endtask

  initial begin
    rst_n = 1'b0;
    a.resolve_valid = 0; a.br_ctrl = 2'b00; a.aluout = '0; a.mem_data = '0;
    a.predict_addr = '0; a.redirect_ready = 0;
    b.resolve_valid = 0; b.br_ctrl = 2'b00; b.aluout = '0; b.mem_data = '0;
    b.predict_addr = '0; b.redirect_ready = 0;

    // Reset state
    tick();
    chk_a("reset", 0, 0, 0, 16'd0, 16'd0);
    chk("reset.pc", 32'(a.redirect_pc), 32'h0);
    rst_n = 1'b1;

    // 1. Correct prediction
    a.resolve_valid = 1; a.br_ctrl = 2'b01; a.aluout = 16'h3000; a.predict_addr = 16'h3002;
    tick();
    a.resolve_valid = 0;
    chk_a("t1", 0, 0, 0, 16'd1, 16'd0);

    // 2. ALU mispredict, ready high
    a.resolve_valid = 1; a.aluout = 16'h4000; a.redirect_ready = 1;
    tick();
    a.resolve_valid = 0;
    chk_a("t2.c1", 1, 1, 1, 16'd2, 16'd1);
    chk("t2.pc", 32'(a.redirect_pc), 32'h4002);
    tick();
    chk_a("t2.c2", 1, 0, 1, 16'd2, 16'd1);
    tick();
    chk_a("t2.c3", 1, 0, 1, 16'd2, 16'd1);
    tick();
    chk_a("t2.c4", 0, 0, 0, 16'd2, 16'd1);

    // 3. Memory target wraps modulo 2^16
    a.resolve_valid = 1; a.br_ctrl = 2'b10; a.mem_data = 16'hFFFF; a.predict_addr = 16'h0000;
    tick();
    a.resolve_valid = 0;
    chk_a("t3.c1", 1, 1, 1, 16'd3, 16'd2);
    chk("t3.pc", 32'(a.redirect_pc), 32'h0001);
    tick(); tick(); tick();
    chk_a("t3.done", 0, 0, 0, 16'd3, 16'd2);

    // Reserved br_ctrl and resolve_valid=0 with mismatching data: no action
    a.resolve_valid = 1; a.br_ctrl = 2'b11; a.aluout = 16'h5555; a.mem_data = 16'h5555;
    tick();
    chk_a("na.br11", 0, 0, 0, 16'd3, 16'd2);
    a.resolve_valid = 0; a.br_ctrl = 2'b01;
    tick();
    chk_a("na.novld", 0, 0, 0, 16'd3, 16'd2);

    // 4. Ready low; mismatching resolves held during recovery are ignored
    a.redirect_ready = 0; a.resolve_valid = 1; a.br_ctrl = 2'b01;
    a.aluout = 16'h1000; a.predict_addr = 16'h0000;
    tick();
    a.aluout = 16'h2222;
    for (int c = 1; c <= 6; c++) begin
      chk_a($sformatf("t4.c%0d", c), (c <= 3), 1, 1, 16'd4, 16'd3);
      chk($sformatf("t4.pc%0d", c), 32'(a.redirect_pc), 32'h1002);
      tick();
    end
    a.resolve_valid = 0; a.redirect_ready = 1;
    #1;
    chk_a("t4.hs", 0, 1, 1, 16'd4, 16'd3);
    tick();
    chk_a("t4.idle", 0, 0, 0, 16'd4, 16'd3);

    // 5. Back-to-back mismatch in first IDLE cycle, then reset mid-FLUSH
    a.resolve_valid = 1; a.aluout = 16'h6000; a.redirect_ready = 0;
    tick();
    a.resolve_valid = 0;
    chk_a("t5.flush", 1, 1, 1, 16'd5, 16'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_a("t5.rst", 0, 0, 0, 16'd0, 16'd0);
    chk("t5.rst.pc", 32'(a.redirect_pc), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_a("t5.post", 0, 0, 0, 16'd0, 16'd0);

    // 6. 4-bit counters saturate after 20 mispredicts
    b.redirect_ready = 1; b.br_ctrl = 2'b01; b.predict_addr = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      b.aluout = 16'(16'h0100 + i * 16);
      b.resolve_valid = 1;
      tick();
      b.resolve_valid = 0;
      tick(); tick(); tick();
    end
    chk("t6.brcnt", 32'(b_br), 32'd15);
    chk("t6.mpcnt", 32'(b_mp), 32'd15);
    chk("t6.idle", 32'(b.stall_resolve), 32'd0);
    b.resolve_valid = 1; b.br_ctrl = 2'b11; b.aluout = 16'h1234; b.mem_data = 16'h1234;
    tick();
    chk("t6.br11.flush", 32'(b.flush), 32'd0);
    chk("t6.br11.stall", 32'(b.stall_resolve), 32'd0);
    b.resolve_valid = 0; b.br_ctrl = 2'b01;
    tick();
    chk("t6.novld.flush", 32'(b.flush), 32'd0);
    chk("t6.novld.rv", 32'(b.redirect_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
